mux_n_1_rr: RTL

Registered N-to-1 channel multiplexer with valid/ready handshakes on every input and on the output, generalising the combinational 4:1 mux family to N channels of W bits. Two selection modes: fixed (external select, like the existing muxes) and round-robin across valid channels. Sits between multiple producer channels and a single consumer. Provides one-cycle registered latency, full throughput, and backpressure.

---
 rtl/mux_n_1_rr.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_n_1_rr.sv
// Registered N:1 channel mux with valid/ready on every port.
// Selection is either a fixed external index or round-robin over valid channels.
module mux_n_1_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mode,
  input  logic [SW-1:0]   i_sel,
  input  logic [N*W-1:0]  i_in_data,
  input  logic [N-1:0]    i_in_valid,
  output logic [N-1:0]    o_in_ready,
  output logic [W-1:0]    o_out_data,
  output logic [SW-1:0]   o_out_ch,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [15:0]     o_beat_cnt
);

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;
  logic          r_out_valid;
  logic [SW-1:0] r_ptr;
  logic [15:0]   r_beat_cnt;

  logic [SW:0]   w_dist [N];
  logic [SW:0]   w_best_dist;
  logic          w_cand_vld;
  logic [SW-1:0] w_cand_ch;
  logic [W-1:0]  w_cand_data;
  logic          w_ld;
  logic          w_grant;
  logic          w_consume;
  logic [SW-1:0] w_ptr_nxt;

  // Distance of each channel from the round-robin pointer, modulo N.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      if ((SW+1)'(c) >= {1'b0, r_ptr}) begin
        w_dist[c] = (SW+1)'(c) - {1'b0, r_ptr};
      end else begin
        w_dist[c] = (SW+1)'(c) + (SW+1)'(N) - {1'b0, r_ptr};
      end
    end
  end

  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_ch   = '0;
    w_best_dist = '1;
    if (i_mode) begin
      for (int c = 0; c < N; c++) begin
        if (i_in_valid[c] && (!w_cand_vld || (w_dist[c] < w_best_dist))) begin
          w_cand_vld  = 1'b1;
          w_cand_ch   = SW'(c);
          w_best_dist = w_dist[c];
        end
      end
    end else begin
      // Out-of-range selects never match any channel, so they never grant.
      for (int c = 0; c < N; c++) begin
        if ((i_sel == SW'(c)) && i_in_valid[c]) begin
          w_cand_vld = 1'b1;
          w_cand_ch  = SW'(c);
        end
      end
    end
  end

  always_comb begin
    w_cand_data = '0;
    for (int c = 0; c < N; c++) begin
      if (w_cand_ch == SW'(c)) begin
        w_cand_data = i_in_data[c*W +: W];
      end
    end
  end

  assign w_ld      = !r_out_valid || i_out_ready;
  assign w_grant   = w_cand_vld && w_ld && !i_rst;
  assign w_consume = r_out_valid && i_out_ready;
  assign w_ptr_nxt = (w_cand_ch == SW'(N-1)) ? '0 : w_cand_ch + 1'b1;

  always_comb begin
    o_in_ready = '0;
    for (int c = 0; c < N; c++) begin
      o_in_ready[c] = w_grant && (w_cand_ch == SW'(c));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_consume) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if (w_grant) begin
        r_out_data  <= w_cand_data;
        r_out_ch    <= w_cand_ch;
        r_out_valid <= 1'b1;
        r_ptr       <= w_ptr_nxt;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = r_out_valid;
  assign o_beat_cnt  = r_beat_cnt;

endmodule
